sprite_linebuf_shifter: RTL and testbench
=========================================

SPRITE_LINEBUF_SHIFTER -- requirements
Module: sprite_linebuf_shifter

Role: consumer of the 15B PAL control strobes (PLOAD_RSHIFTn, RL_Sel, AB_Sel, VLK, G15_CE).
- Serialises 4-bitplane sprite data into a double-buffered line buffer.
- Reads the opposite bank out to video.

Interface
REQ-001 SHALL: clk  input  1  system clock.
REQ-002 SHALL: Reset_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL: Cen  input  1  pixel clock enable; acted on at its rising edge only.
REQ-004 SHALL: PLOAD_RSHIFTn  input  1  0 = parallel load, 1 = shift.
REQ-005 SHALL: RL_Sel  input  1  shift direction: 0 = MSB first, 1 = LSB first (h-flip).
REQ-006 SHALL: AB_Sel  input  1  write-bank select; the read bank is ~AB_Sel.
REQ-007 SHALL: VLK  input  1  write enable: 1 = writes permitted, 0 = writes inhibited.
REQ-008 SHALL: G15_CE  input  1  write-address increment enable.
REQ-009 SHALL: PIX_DATA  input  32  plane p occupies bits [8p+7:8p], p = 0..3.
REQ-010 SHALL: XPOS  input  8  start write address, captured at load.
REQ-011 SHALL: HCNT  input  8  read-out address.
REQ-012 SHALL: PIX_OUT  output  4  registered read-out pixel.
REQ-013 SHALL: SR_EMPTY  output  1  1 = shift register has no pixels remaining.

Function
REQ-014 SHALL: tick = Cen & ~last_cen, with last_cen registered every clk; all state below changes only on a tick clk.
REQ-015 SHALL: load on a tick with PLOAD_RSHIFTn=0:
- 4 plane registers <= PIX_DATA.
- waddr <= XPOS.
- cnt <= 8.
- SR_EMPTY <= 0.
- No line-buffer write on that tick.
REQ-016 SHALL: load has priority over shift; a load on a tick while cnt>0 discards the remaining pixels.
REQ-017 SHALL: shift on a tick with PLOAD_RSHIFTn=1 and cnt>0:
- pixel = {plane3,plane2,plane1,plane0} bit 7 when RL_Sel=0, or bit 0 when RL_Sel=1.
- Planes shift toward the selected end with zero fill.
- cnt decrements by 1.
REQ-018 SHALL: RL_Sel is sampled on every shift tick; a change mid-sprite takes effect on the next pixel.
REQ-019 SHALL: shifted pixel write: written to bank[AB_Sel][waddr] only when pixel != 0 and VLK=1. A zero pixel is transparent and leaves the location unchanged.
REQ-020 SHALL: on a shift tick with G15_CE=1, waddr <= waddr+1 modulo 256 (255 wraps to 0), regardless of transparency; with G15_CE=0, waddr holds.
REQ-021 SHALL: SR_EMPTY rises on the tick cnt reaches 0. Shift ticks with cnt=0 perform no write and no waddr change.
REQ-022 SHALL: read/clear on every tick:
- bank[~AB_Sel][HCNT] is read, then cleared to 0 (read-before-clear).
- PIX_OUT presents the read value from the next tick until the following tick.
REQ-023 SHALL: write and clear always target opposite banks on the same tick, so no collision case exists.
REQ-024 SHALL: an AB_Sel toggle applies on the next tick to both the write and read paths. A sprite in flight continues into the new write bank.
REQ-025 SHALL: line buffer is 2 banks x 256 entries x 4 bits, with one write port and one read/clear port per bank.

Reset
REQ-026 SHALL: Reset_n=0 on a clk edge sets:
- PIX_OUT=0, SR_EMPTY=1, cnt=0, waddr=0.
- Plane registers=0.
- last_cen=1, so no tick fires on the first clk after release even if Cen=1.
REQ-027 SHALL: reset does not initialise line-buffer contents; contents are defined only after a bank has been fully read (cleared).
REQ-028 SHALL: a reset asserted mid-shift abandons the sprite; no further writes occur from it.

Verification
REQ-029 SHALL: clear both banks by reading all 256 HCNT values with AB_Sel=0, then with AB_Sel=1.
- Then load PIX_DATA=0x000000FF, XPOS=0x10, RL_Sel=0, VLK=1, G15_CE=1 with AB_Sel=0, and shift 8 ticks.
- Then set AB_Sel=1 and read HCNT 0x10..0x17.
- Required: PIX_OUT=1 for each of 0x10..0x17; SR_EMPTY=1 after the 8th shift; a re-read returns 0.
REQ-030 SHALL: h-flip: PIX_DATA plane0=0x80, plane3=0x01, XPOS=0x20, RL_Sel=1, 8 shifts.
- Required: addr 0x20=8, addr 0x27=1, addrs 0x21..0x26 unchanged.
REQ-031 SHALL: wrap and transparency: XPOS=0xFE, PIX_DATA=0x000000AA, RL_Sel=0.
- Required: addrs 0xFE, 0x00, 0x02, 0x04 = 1; addrs 0xFF, 0x01, 0x03, 0x05 retain their prior non-zero preload.
REQ-032 SHALL: VLK=0 throughout a full sprite shift -> no bank location changes; with G15_CE=0 -> all non-zero pixels land on the single address XPOS, last non-zero pixel wins.
REQ-033 SHALL: load issued after 3 shifts -> cnt restarts at 8, waddr=new XPOS, remaining old pixels never written; holding Cen=1 high for many clks -> exactly one tick.
REQ-034 SHALL: Reset_n=0 for one clk after 4 shifts, with Cen=1 at release -> no tick on the first clk after release; SR_EMPTY=1 and PIX_OUT=0; the remaining 4 pixels are absent from the buffer.

Source files
------------

// File: rtl/sprite_linebuf_shifter.sv
// Sprite line-buffer shifter: serialises four 8-bit bitplanes into a double-buffered
// 2x256x4 line buffer and reads/clears the opposite bank out to video.
module sprite_linebuf_shifter (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        Cen,
    input  logic        PLOAD_RSHIFTn,
    input  logic        RL_Sel,
    input  logic        AB_Sel,
    input  logic        VLK,
    input  logic        G15_CE,
    input  logic [31:0] PIX_DATA,
    input  logic [7:0]  XPOS,
    input  logic [7:0]  HCNT,
    output logic [3:0]  PIX_OUT,
    output logic        SR_EMPTY
);

    localparam int unsigned NUM_BANKS   = 2;
    localparam int unsigned BANK_DEPTH  = 256;
    localparam logic [3:0]  SPRITE_PIXELS = 4'd8;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_LOAD,
        OP_SHIFT
    } op_e;

    logic            last_cen_q, last_cen_d;
    logic [3:0][7:0] plane_q, plane_d;
    logic [7:0]      waddr_q, waddr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            sr_empty_q, sr_empty_d;
    logic [3:0]      pix_out_q, pix_out_d;

    logic            tick;
    op_e             op;
    logic [3:0]      shift_pix;
    logic            wr_en;
    logic [3:0]      bank_rdata [NUM_BANKS];
    logic [3:0]      rd_data;

    // Ticks are suppressed while in reset so an abandoned sprite cannot write.
    assign tick = Cen & ~last_cen_q & Reset_n;

    assign shift_pix = RL_Sel ? {plane_q[3][0], plane_q[2][0], plane_q[1][0], plane_q[0][0]}
                              : {plane_q[3][7], plane_q[2][7], plane_q[1][7], plane_q[0][7]};

    assign rd_data = bank_rdata[!AB_Sel];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        last_cen_d = Cen;
        plane_d    = plane_q;
        waddr_d    = waddr_q;
        cnt_d      = cnt_q;
        sr_empty_d = sr_empty_q;
        pix_out_d  = pix_out_q;
        op         = OP_IDLE;
        wr_en      = 1'b0;

        if (tick) begin
            if (!PLOAD_RSHIFTn) begin
                op = OP_LOAD;
            end else if (cnt_q != 4'd0) begin
                op = OP_SHIFT;
            end
            pix_out_d = rd_data;
        end

        case (op)
            OP_LOAD: begin
                plane_d    = PIX_DATA;
                waddr_d    = XPOS;
                cnt_d      = SPRITE_PIXELS;
                sr_empty_d = 1'b0;
            end
            OP_SHIFT: begin
                wr_en = (shift_pix != 4'd0) && VLK;
                for (int p = 0; p < 4; p++) begin
                    plane_d[p] = RL_Sel ? (plane_q[p] >> 1) : (plane_q[p] << 1);
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    sr_empty_d = 1'b1;
                end
                if (G15_CE) begin
                    waddr_d = waddr_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: synchronous reset, and all sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            last_cen_q <= 1'b1;
            plane_q    <= '0;
            waddr_q    <= 8'd0;
            cnt_q      <= 4'd0;
            sr_empty_q <= 1'b1;
            pix_out_q  <= 4'd0;
        end else begin
            last_cen_q <= last_cen_d;
            plane_q    <= plane_d;
            waddr_q    <= waddr_d;
            cnt_q      <= cnt_d;
            sr_empty_q <= sr_empty_d;
            pix_out_q  <= pix_out_d;
        end
    end

    // Each bank is either the write bank or the read/clear bank on a tick, never both,
    // so a single address/data port per bank serves both roles.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [3:0] mem [BANK_DEPTH];
        logic       is_wr_bank;
        logic [7:0] addr;
        logic [3:0] wdata;
        logic       we;

        assign is_wr_bank = (AB_Sel == 1'(b));
        assign addr       = is_wr_bank ? waddr_q : HCNT;
        assign wdata      = is_wr_bank ? shift_pix : 4'd0;
        assign we         = tick & (is_wr_bank ? wr_en : 1'b1);
        assign bank_rdata[b] = mem[HCNT];

        // NOTE: the buffer is deliberately not reset; a full read-out pass clears it.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

    assign PIX_OUT  = pix_out_q;
    assign SR_EMPTY = sr_empty_q;

endmodule

// File: tb/tb_sprite_linebuf_shifter.sv
// Scoreboard bench for sprite_linebuf_shifter: a behavioural line-buffer model predicts
// PIX_OUT/SR_EMPTY for every tick; predictions are queued and compared after the edge.
module tb_sprite_linebuf_shifter;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic        Cen;
    logic        PLOAD_RSHIFTn;
    logic        RL_Sel;
    logic        AB_Sel;
    logic        VLK;
    logic        G15_CE;
    logic [31:0] PIX_DATA;
    logic [7:0]  XPOS;
    logic [7:0]  HCNT;
    logic [3:0]  PIX_OUT;
    logic        SR_EMPTY;

    always #5 clk = ~clk;

    sprite_linebuf_shifter dut (
        .clk           (clk),
        .Reset_n       (Reset_n),
        .Cen           (Cen),
        .PLOAD_RSHIFTn (PLOAD_RSHIFTn),
        .RL_Sel        (RL_Sel),
        .AB_Sel        (AB_Sel),
        .VLK           (VLK),
        .G15_CE        (G15_CE),
        .PIX_DATA      (PIX_DATA),
        .XPOS          (XPOS),
        .HCNT          (HCNT),
        .PIX_OUT       (PIX_OUT),
        .SR_EMPTY      (SR_EMPTY)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [3:0] m_mem [2][256];
    logic [7:0] m_plane [4];
    logic [7:0] m_waddr;
    int         m_cnt;
    logic       m_empty;
    logic [3:0] m_pix_out;

    typedef struct {
        logic [3:0] pix;
        logic       empty;
        string      tag;
    } exp_t;

    exp_t sb [$];

    task automatic model_reset();
        for (int p = 0; p < 4; p++) m_plane[p] = 8'h00;
        m_waddr   = 8'h00;
        m_cnt     = 0;
        m_empty   = 1'b1;
        m_pix_out = 4'h0;
    endtask

    // One tick of the spec behaviour, using the currently driven inputs.
    task automatic model_tick();
        logic [3:0] rd;
        logic [3:0] pix;
        int wb;
        int rb;
        wb = AB_Sel ? 1 : 0;
        rb = 1 - wb;
        rd = m_mem[rb][HCNT];
        m_mem[rb][HCNT] = 4'h0;
        if (!PLOAD_RSHIFTn) begin
            m_plane[0] = PIX_DATA[7:0];
            m_plane[1] = PIX_DATA[15:8];
            m_plane[2] = PIX_DATA[23:16];
            m_plane[3] = PIX_DATA[31:24];
            m_waddr    = XPOS;
            m_cnt      = 8;
            m_empty    = 1'b0;
        end else if (m_cnt > 0) begin
            if (RL_Sel) pix = {m_plane[3][0], m_plane[2][0], m_plane[1][0], m_plane[0][0]};
            else        pix = {m_plane[3][7], m_plane[2][7], m_plane[1][7], m_plane[0][7]};
            if (pix != 4'h0 && VLK) m_mem[wb][m_waddr] = pix;
            for (int p = 0; p < 4; p++)
                m_plane[p] = RL_Sel ? (m_plane[p] >> 1) : (m_plane[p] << 1);
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_empty = 1'b1;
            if (G15_CE) m_waddr = m_waddr + 8'd1;
        end
        m_pix_out = rd;
    endtask

    task automatic compare_outputs(input exp_t e, input string phase);
        if (!$isunknown(e.pix)) begin
            checks++;
            if (PIX_OUT !== e.pix) begin
                errors++;
                $display("FAIL %s/%s pix_out: got %h expected %h (hcnt=%h)", e.tag, phase, PIX_OUT, e.pix, HCNT);
            end
        end
        checks++;
        if (SR_EMPTY !== e.empty) begin
            errors++;
            $display("FAIL %s/%s sr_empty: got %b expected %b", e.tag, phase, SR_EMPTY, e.empty);
        end
    endtask

    // One Cen pulse: tick edge, then an idle edge where outputs must hold.
    task automatic tick_op(input logic load_n, input logic rl, input logic ab, input logic vlk,
                           input logic g15, input logic [31:0] data, input logic [7:0] xpos,
                           input logic [7:0] hcnt, input string tag);
        exp_t e;
        PLOAD_RSHIFTn = load_n;
        RL_Sel        = rl;
        AB_Sel        = ab;
        VLK           = vlk;
        G15_CE        = g15;
        PIX_DATA      = data;
        XPOS          = xpos;
        HCNT          = hcnt;
        Cen           = 1'b1;
        model_tick();
        sb.push_back('{pix: m_pix_out, empty: m_empty, tag: tag});
        @(posedge clk); #1;
        e = sb.pop_front();
        compare_outputs(e, "tick");
        Cen = 1'b0;
        @(posedge clk); #1;
        compare_outputs(e, "hold");
    endtask

    task automatic load_op(input logic [31:0] data, input logic [7:0] xpos, input logic ab);
        tick_op(1'b0, 1'b0, ab, 1'b1, 1'b1, data, xpos, 8'h00, "load");
    endtask

    task automatic shift_n(input int n, input logic rl, input logic ab, input logic vlk, input logic g15);
        for (int i = 0; i < n; i++) tick_op(1'b1, rl, ab, vlk, g15, 32'h0, 8'h00, 8'h00, "shift");
    endtask

    // Reads (and clears) bank ~ab over n consecutive addresses starting at lo.
    task automatic read_range(input logic ab, input logic [7:0] lo, input int n);
        for (int i = 0; i < n; i++) tick_op(1'b1, 1'b0, ab, 1'b0, 1'b1, 32'h0, 8'h00, 8'(lo + 8'(i)), "read");
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Cen = 1'b0; PLOAD_RSHIFTn = 1'b1; RL_Sel = 1'b0; AB_Sel = 1'b0;
        VLK = 1'b0; G15_CE = 1'b0; PIX_DATA = 32'h0; XPOS = 8'h0; HCNT = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (PIX_OUT !== 4'h0) begin errors++; $display("FAIL reset pix_out: got %h expected 0", PIX_OUT); end
        checks++;
        if (SR_EMPTY !== 1'b1) begin errors++; $display("FAIL reset sr_empty: got %b expected 1", SR_EMPTY); end
        Reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clear_and_basic();
        read_range(1'b0, 8'h00, 256);
        read_range(1'b1, 8'h00, 256);
        load_op(32'h0000_00FF, 8'h10, 1'b0);
        shift_n(8, 1'b0, 1'b0, 1'b1, 1'b1);
        read_range(1'b1, 8'h0F, 10);
        read_range(1'b1, 8'h10, 8);
    endtask

    task automatic test_hflip();
        load_op(32'h0100_0080, 8'h20, 1'b0);
        shift_n(8, 1'b1, 1'b0, 1'b1, 1'b1);
        read_range(1'b1, 8'h1F, 10);
    endtask

    task automatic test_wrap_transparency();
        load_op(32'hFF00_0000, 8'hFE, 1'b0);
        shift_n(8, 1'b0, 1'b0, 1'b1, 1'b1);
        load_op(32'h0000_00AA, 8'hFE, 1'b0);
        shift_n(8, 1'b0, 1'b0, 1'b1, 1'b1);
        read_range(1'b1, 8'hFC, 12);
    endtask

    task automatic test_vlk_and_g15();
        load_op(32'h0000_00FF, 8'h60, 1'b0);
        shift_n(8, 1'b0, 1'b0, 1'b1, 1'b1);
        load_op(32'h0F0F_0F0F, 8'h60, 1'b0);
        shift_n(8, 1'b0, 1'b0, 1'b0, 1'b1);
        load_op(32'h0000_0F3C, 8'h70, 1'b0);
        shift_n(8, 1'b0, 1'b0, 1'b1, 1'b0);
        read_range(1'b1, 8'h5E, 22);
    endtask

    task automatic test_reload();
        load_op(32'h0000_00FF, 8'h80, 1'b0);
        shift_n(3, 1'b0, 1'b0, 1'b1, 1'b1);
        load_op(32'h0000_FF00, 8'h90, 1'b0);
        shift_n(8, 1'b0, 1'b0, 1'b1, 1'b1);
        read_range(1'b1, 8'h7F, 28);
    endtask

    task automatic test_cen_hold();
        exp_t e;
        load_op(32'h0000_00FF, 8'hA0, 1'b0);
        PLOAD_RSHIFTn = 1'b1; RL_Sel = 1'b0; AB_Sel = 1'b0;
        VLK = 1'b1; G15_CE = 1'b1; HCNT = 8'h00;
        Cen = 1'b1;
        model_tick();
        sb.push_back('{pix: m_pix_out, empty: m_empty, tag: "cen_hold"});
        repeat (10) @(posedge clk);
        #1;
        e = sb.pop_front();
        compare_outputs(e, "held");
        Cen = 1'b0;
        @(posedge clk); #1;
        read_range(1'b1, 8'h9F, 10);
    endtask

    task automatic test_reset_mid_shift();
        load_op(32'h0000_00FF, 8'hC0, 1'b0);
        shift_n(4, 1'b0, 1'b0, 1'b1, 1'b1);
        // A spurious tick after release would read/clear bank0[0xC0] (holding 1).
        AB_Sel = 1'b1; HCNT = 8'hC0; PLOAD_RSHIFTn = 1'b1;
        Reset_n = 1'b0; Cen = 1'b1;
        @(posedge clk); #1;
        model_reset();
        Reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (SR_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_mid sr_empty: got %b expected 1", SR_EMPTY); end
        checks++;
        if (PIX_OUT !== 4'h0) begin errors++; $display("FAIL reset_mid pix_out: got %h expected 0", PIX_OUT); end
        Cen = 1'b0;
        @(posedge clk); #1;
        shift_n(4, 1'b0, 1'b0, 1'b1, 1'b1);
        read_range(1'b1, 8'hBF, 10);
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) m_mem[b][a] = 4'bxxxx;
        test_reset();
        test_clear_and_basic();
        test_hflip();
        test_wrap_transparency();
        test_vlk_and_g15();
        test_reload();
        test_cen_hold();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
